// File: rtl/layer_argmax.sv
// Argmax classifier stage: consumes an M-element signed vector and emits the index of its maximum.
// Define ARGMAX_VALUE_OUT_EN to emit a second beat carrying the signed maximum value.
//
// state      | meaning
// INIT       | one idle cycle after reset, input not yet accepted
// COLLECT    | accepting vector elements, tracking running max and its index
// OUT_IDX    | presenting the winning index, waiting for m_ready
// OUT_VAL    | presenting the max value (ARGMAX_VALUE_OUT_EN only)
module layer_argmax #(
  parameter int M     = 8,
  parameter int LOGM  = 3,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] data_in,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] data_out
);

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_COLLECT = 2'd1,
`ifdef ARGMAX_VALUE_OUT_EN
    ST_OUT_IDX = 2'd2,
    ST_OUT_VAL = 2'd3
`else
    ST_OUT_IDX = 2'd2
`endif
  } state_t;

  state_t                    state_q, state_d;
  logic [LOGM-1:0]           cnt_q, cnt_d;
  logic signed [WIDTH-1:0]   max_q, max_d;
  logic [LOGM-1:0]           idx_q, idx_d;
  logic                      s_ready_q, s_ready_d;
  logic                      m_valid_q, m_valid_d;
  logic [WIDTH-1:0]          data_out_q, data_out_d;

  logic                      accept;
  logic                      is_max;
  logic                      last_elem;

  assign s_ready  = s_ready_q;
  assign m_valid  = m_valid_q;
  assign data_out = data_out_q;

  assign accept    = s_valid && s_ready_q;
  // Element 0 always wins so the running max never depends on a stale value.
  assign is_max    = (cnt_q == '0) || ($signed(data_in) > max_q);
  assign last_elem = (cnt_q == LOGM'(M - 1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    max_d      = max_q;
    idx_d      = idx_q;
    s_ready_d  = s_ready_q;
    m_valid_d  = m_valid_q;
    data_out_d = data_out_q;

    case (state_q)
      ST_INIT: begin
        state_d   = ST_COLLECT;
        s_ready_d = 1'b1;
      end

      ST_COLLECT: begin
        if (accept) begin
          if (is_max) begin
            max_d = $signed(data_in);
            idx_d = cnt_q;
          end
          if (last_elem) begin
            cnt_d      = '0;
            s_ready_d  = 1'b0;
            m_valid_d  = 1'b1;
            data_out_d = WIDTH'(is_max ? cnt_q : idx_q);
            state_d    = ST_OUT_IDX;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      ST_OUT_IDX: begin
        if (m_ready) begin
`ifdef ARGMAX_VALUE_OUT_EN
          data_out_d = max_q;
          state_d    = ST_OUT_VAL;
`else
          m_valid_d = 1'b0;
          s_ready_d = 1'b1;
          state_d   = ST_COLLECT;
`endif
        end
      end

`ifdef ARGMAX_VALUE_OUT_EN
      ST_OUT_VAL: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          s_ready_d = 1'b1;
          state_d   = ST_COLLECT;
        end
      end
`endif

      default: begin
        state_d   = ST_INIT;
        s_ready_d = 1'b0;
        m_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_INIT;
      cnt_q      <= '0;
      max_q      <= '0;
      idx_q      <= '0;
      s_ready_q  <= 1'b0;
      m_valid_q  <= 1'b0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      max_q      <= max_d;
      idx_q      <= idx_d;
      s_ready_q  <= s_ready_d;
      m_valid_q  <= m_valid_d;
      data_out_q <= data_out_d;
    end
  end

endmodule

// File: tb/tb_layer_argmax.sv
// Scoreboard bench for layer_argmax: driver pushes expected beats from a reference argmax model,
// a negedge monitor pops and compares every accepted output beat.
module tb_layer_argmax;
  localparam int M     = 8;
  localparam int LOGM  = 3;
  localparam int WIDTH = 16;

  typedef logic signed [WIDTH-1:0] vec_t [M];

  logic             clk = 1'b0;
  logic             reset;
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] data_in;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] data_out;

  int checks   = 0;
  int failures = 0;
  int beats    = 0;
  int accepts  = 0;
  logic [WIDTH-1:0] sb_q [$];

`ifdef ARGMAX_VALUE_OUT_EN
  localparam int BEATS_PER_VEC = 2;
`else
  localparam int BEATS_PER_VEC = 1;
`endif

  layer_argmax #(.M(M), .LOGM(LOGM), .WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .data_in  (data_in),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: first index holding the largest signed value, plus that value.
  task automatic push_expected(input vec_t v);
    int best = 0;
    for (int i = 1; i < M; i++)
      if (v[i] > v[best]) best = i;
    sb_q.push_back(WIDTH'(best));
`ifdef ARGMAX_VALUE_OUT_EN
    sb_q.push_back(v[best]);
`endif
  endtask

  initial begin
    logic [WIDTH-1:0] exp;
    forever begin
      @(negedge clk);
      if (!reset && s_valid && s_ready) accepts++;
      if (!reset && m_valid && m_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat actual=%h required=none", data_out);
        end else begin
          exp = sb_q.pop_front();
          check("result_beat", data_out, exp);
          beats++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: s_valid held high, 1: alternating, 2: random
  task automatic send_vec(input vec_t v, input int mode, input bit rnd_ready);
    logic tog = 1'b1;
    for (int i = 0; i < M; i++) begin
      int budget = 0;
      bit acc = 0;
      while (!acc) begin
        if (mode == 1) tog = ~tog;
        s_valid = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
        data_in = s_valid ? v[i] : WIDTH'($urandom);
        if (rnd_ready) m_ready = 1'($urandom_range(0, 1));
        acc = s_valid && s_ready;
        if (acc && i == M - 1) push_expected(v);
        tick();
        budget++;
        if (budget > 200) begin
          failures++;
          $display("FAIL accept_timeout actual=no_accept required=accept element=%0d", i);
          $fatal(1, "input handshake stalled");
        end
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic drain();
    int budget = 0;
    while (sb_q.size() != 0 && budget < 200) begin
      m_ready = 1'b1;
      tick();
      budget++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d required=0 pending", sb_q.size());
    end
    m_ready = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    vec_t v;
    int b0;
    int a0;
    reset   = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b1;
    data_in = '0;
    repeat (3) tick();
    check("rst_s_ready", WIDTH'(s_ready), 16'd0);
    check("rst_m_valid", WIDTH'(m_valid), 16'd0);
    check("rst_data_out", data_out, 16'd0);
    reset = 1'b0;
    check("init_s_ready", WIDTH'(s_ready), 16'd0);
    tick();
    check("s_ready_rise", WIDTH'(s_ready), 16'd1);

    // Basic vector with latency and s_ready return timing.
    v = '{-60, -95, 21, 122, -49, 98, 95, 44};
    send_vec(v, 0, 0);
    check("mv_after_last", WIDTH'(m_valid), 16'd1);
    check("idx_basic", data_out, 16'd3);
    check("sr_low_out", WIDTH'(s_ready), 16'd0);
    tick();
`ifdef ARGMAX_VALUE_OUT_EN
    check("val_beat", data_out, 16'h007A);
    check("mv_val_beat", WIDTH'(m_valid), 16'd1);
    tick();
`endif
    check("mv_drop", WIDTH'(m_valid), 16'd0);
    check("sr_return", WIDTH'(s_ready), 16'd1);

    v = '{5, 7, 7, 1, 0, 0, 7, 2};
    send_vec(v, 0, 0);
    check("idx_ties", data_out, 16'd1);
    drain();
    v = '{-1, -2, -3, -4, -5, -6, -7, -8};
    send_vec(v, 0, 0);
    check("idx_neg", data_out, 16'd0);
    drain();

    // Backpressure with ignored s_valid pulses.
    b0 = beats;
    a0 = accepts;
    m_ready = 1'b0;
    v = '{-60, -95, 21, 122, -49, 98, 95, 44};
    send_vec(v, 0, 0);
    for (int c = 0; c < 5; c++) begin
      s_valid = 1'($urandom_range(0, 1));
      data_in = WIDTH'($urandom);
      check("bp_data_hold", data_out, 16'd3);
      check("bp_m_valid", WIDTH'(m_valid), 16'd1);
      check("bp_s_ready", WIDTH'(s_ready), 16'd0);
      tick();
    end
    s_valid = 1'b0;
    drain();
    check("bp_beats_once", WIDTH'(beats - b0), WIDTH'(BEATS_PER_VEC));
    check("bp_accepts", WIDTH'(accepts - a0), WIDTH'(M));
    check("bp_mv_idle", WIDTH'(m_valid), 16'd0);

    // Throttled input.
    a0 = accepts;
    v = '{0, 0, 0, 0, 0, 0, 0, 9};
    send_vec(v, 1, 0);
    check("idx_throttle", data_out, 16'd7);
    drain();
    check("throttle_accepts", WIDTH'(accepts - a0), WIDTH'(M));

    // Reset mid-vector discards the partial 100s.
    b0 = beats;
    s_valid = 1'b1;
    data_in = 16'd100;
    repeat (4) tick();
    s_valid = 1'b0;
    reset = 1'b1;
    tick();
    check("midrst_s_ready", WIDTH'(s_ready), 16'd0);
    check("midrst_m_valid", WIDTH'(m_valid), 16'd0);
    reset = 1'b0;
    v = '{1, 2, 3, 4, 5, 6, 7, 8};
    send_vec(v, 0, 0);
    check("idx_after_rst", data_out, 16'd7);
    drain();
    check("rst_beats", WIDTH'(beats - b0), WIDTH'(BEATS_PER_VEC));

    // Randomized vectors, random gaps and random backpressure.
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < M; i++)
        v[i] = (n % 2 == 0) ? WIDTH'($urandom_range(0, 6)) - 16'sd3 : WIDTH'($urandom);
      send_vec(v, 2, 1);
    end
    drain();
    check("sb_empty", WIDTH'(sb_q.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
